calendar_counter: RTL

- Parametrised calendar date counter that holds day, month and year.
- Advances one day per qualified tick, with correct month lengths and leap-year handling.
- Successor to the team's combinational 31-day-month decoder: adds per-month length, February leap handling, validated loads and rollover strobes.
- Sits behind an RTC/seconds prescaler that supplies a one-cycle day tick.

---
 rtl/calendar_counter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/calendar_counter.sv
// Calendar date counter: day/month/year with per-month lengths, leap years,
// validated loads and registered rollover strobes.
module calendar_counter #(
  parameter int YEAR_W    = 12,
  parameter int YEAR_INIT = 2000,
  parameter bit GREGORIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              load,
  input  logic [4:0]        ld_day,
  input  logic [3:0]        ld_month,
  input  logic [YEAR_W-1:0] ld_year,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic [4:0]        dim,
  output logic              is_leap,
  output logic              month_end,
  output logic              year_end,
  output logic              load_err
);

  function automatic logic leap_of(input logic [YEAR_W-1:0] y);
    logic [31:0] yy;
    logic        r;
    yy = 32'(y);
    if (GREGORIAN) begin
      r = (yy % 32'd4 == 32'd0) && ((yy % 32'd100 != 32'd0) || (yy % 32'd400 == 32'd0));
    end else begin
      r = (yy[1:0] == 2'b00);
    end
    return r;
  endfunction

  // Out-of-range months report zero days so any load against them is rejected.
  function automatic logic [4:0] dim_of(input logic [3:0] m, input logic leap);
    logic [4:0] r;
    case (m)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: r = 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                    r = 5'd30;
      4'd2:                                       r = leap ? 5'd29 : 5'd28;
      default:                                    r = 5'd0;
    endcase
    return r;
  endfunction

  logic [4:0]        day_q, day_d;
  logic [3:0]        month_q, month_d;
  logic [YEAR_W-1:0] year_q, year_d;
  logic              month_end_q, month_end_d;
  logic              year_end_q, year_end_d;
  logic              load_err_q, load_err_d;
  logic              load_valid_s;

  assign is_leap      = leap_of(year_q);
  assign dim          = dim_of(month_q, is_leap);
  assign load_valid_s = (ld_day != 5'd0) && (ld_day <= dim_of(ld_month, leap_of(ld_year)));

  // Next-state: load has priority over tick; a tick alongside any load is dropped.
  always_comb begin
    day_d       = day_q;
    month_d     = month_q;
    year_d      = year_q;
    month_end_d = 1'b0;
    year_end_d  = 1'b0;
    load_err_d  = 1'b0;
    if (load) begin
      if (load_valid_s) begin
        day_d   = ld_day;
        month_d = ld_month;
        year_d  = ld_year;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick) begin
      if (day_q < dim) begin
        day_d = day_q + 5'd1;
      end else begin
        day_d       = 5'd1;
        month_end_d = 1'b1;
        if (month_q < 4'd12) begin
          month_d = month_q + 4'd1;
        end else begin
          month_d    = 4'd1;
          year_d     = year_q + YEAR_W'(1);
          year_end_d = 1'b1;
        end
      end
    end else begin
      day_d = day_q;
    end
  end

  // State and strobe registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      day_q       <= 5'd1;
      month_q     <= 4'd1;
      year_q      <= YEAR_W'(YEAR_INIT);
      month_end_q <= 1'b0;
      year_end_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      day_q       <= day_d;
      month_q     <= month_d;
      year_q      <= year_d;
      month_end_q <= month_end_d;
      year_end_q  <= year_end_d;
      load_err_q  <= load_err_d;
    end
  end

  assign day       = day_q;
  assign month     = month_q;
  assign year      = year_q;
  assign month_end = month_end_q;
  assign year_end  = year_end_q;
  assign load_err  = load_err_q;

endmodule
